// File: rtl/sprite_overlay_pkg.sv
// Shared constants, types and the built-in glyph image for the sprite overlay path.
package sprite_overlay_pkg;
    localparam int COL_W       = 11;
    localparam int ROW_W       = 11;
    localparam int COLOR_W_DEF = 12;
    localparam int SEL_W_DEF   = 3;

    typedef logic [SEL_W_DEF-1:0] sprite_idx_t;

    // Glyph image as a parity pattern over the linear bitmap address; address 0 is set.
    function automatic logic rom_bit(input logic [31:0] addr);
        return ~(^(addr & 32'h0000_2025)) ^ (addr[9] & addr[1]);
    endfunction
endpackage

// File: rtl/sprite_overlay_if.sv
// Scan-position, control and pixel-output bundle between the sync counters and the overlay.
interface sprite_overlay_if
    import sprite_overlay_pkg::*;
#(
    parameter int SEL_W   = SEL_W_DEF,
    parameter int COLOR_W = COLOR_W_DEF
);
    logic [COL_W-1:0]   col_addr_sig;
    logic [ROW_W-1:0]   row_addr_sig;
    logic               frame_start;
    logic [SEL_W-1:0]   sprite_sel;
    logic [COLOR_W-1:0] fg_color;
    logic               invert_en;
    logic               blink_en;
    logic               pix_on;
    logic [COLOR_W-1:0] pix_color;
    logic [SEL_W-1:0]   cur_sprite;

    modport master (
        output col_addr_sig, row_addr_sig, frame_start, sprite_sel, fg_color, invert_en, blink_en,
        input  pix_on, pix_color, cur_sprite
    );
    modport slave (
        input  col_addr_sig, row_addr_sig, frame_start, sprite_sel, fg_color, invert_en, blink_en,
        output pix_on, pix_color, cur_sprite
    );
endinterface

// File: rtl/sprite_overlay_rom.sv
// 1-bit synchronous glyph ROM with a configurable number of read-latency stages.
module sprite_overlay_rom
    import sprite_overlay_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 33411,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic              q
);
    logic               rd_bit;
    logic [ROM_LAT-1:0] q_pipe_d;
    logic [ROM_LAT-1:0] q_pipe_q;

    always_comb begin
        rd_bit   = (32'(addr) < 32'(DEPTH)) ? rom_bit(32'(addr)) : 1'b0;
        q_pipe_d = ROM_LAT'({q_pipe_q, rd_bit});
    end

    always_ff @(posedge clk) begin
        q_pipe_q <= q_pipe_d;
    end

    assign q = q_pipe_q[ROM_LAT-1];
endmodule

// File: rtl/sprite_overlay.sv
// Window compare, bitmap address pipeline, frame-synchronous sprite select and blink
// for a ROM-backed 1-bpp overlay; output trails the scan position by 3+ROM_LAT cycles.
module sprite_overlay
    import sprite_overlay_pkg::*;
#(
    parameter int X0           = 100,
    parameter int Y0           = 10,
    parameter int W            = 111,
    parameter int H            = 43,
    parameter int NUM_SPRITES  = 7,
    parameter int SEL_W        = 3,
    parameter int ADDR_W       = 16,
    parameter int ROM_LAT      = 1,
    parameter int COLOR_W      = 12,
    parameter int BLINK_FRAMES = 30
) (
    input logic             clk,
    input logic             rst,
    sprite_overlay_if.slave bus
);
    localparam int DEPTH = NUM_SPRITES * W * H;
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic               in_win;
    logic               vld_p1_d, vld_p1_q;
    logic [COL_W-1:0]   rc_p1_d, rc_p1_q;
    logic [ROW_W-1:0]   rr_p1_d, rr_p1_q;
    logic [SEL_W-1:0]   spr_p1_d, spr_p1_q;
    logic               vld_p2_d, vld_p2_q;
    logic [ADDR_W-1:0]  addr_p2_d, addr_p2_q;
    logic [ROM_LAT-1:0] win_dly_d, win_dly_q;
    logic               rom_q;
    logic               rom_bit_v;
    logic               pix_on_d, pix_on_q;
    logic [COLOR_W-1:0] pix_color_d, pix_color_q;
    logic [SEL_W-1:0]   cur_sprite_d, cur_sprite_q;
    logic [CNT_W-1:0]   blink_cnt_d, blink_cnt_q;
    logic               blink_phase_d, blink_phase_q;

    always_comb begin
        // S1: window compare and window-relative coordinates
        in_win = (bus.col_addr_sig >= COL_W'(X0)) && (bus.col_addr_sig <= COL_W'(X0 + W - 1)) &&
                 (bus.row_addr_sig >= ROW_W'(Y0)) && (bus.row_addr_sig <= ROW_W'(Y0 + H - 1));
        vld_p1_d = in_win;
        rc_p1_d  = in_win ? bus.col_addr_sig - COL_W'(X0) : '0;
        rr_p1_d  = in_win ? bus.row_addr_sig - ROW_W'(Y0) : '0;
        // The sprite travels with the pixel so a same-cycle frame_start cannot retarget it.
        spr_p1_d = cur_sprite_q;

        // S2: linear bitmap address
        vld_p2_d  = vld_p1_q;
        addr_p2_d = vld_p1_q ? ADDR_W'(32'(spr_p1_q) * 32'(W * H) + 32'(rr_p1_q) * 32'(W)
                                       + 32'(rc_p1_q)) : '0;

        // ROM: window flag delayed to match the read latency
        win_dly_d = ROM_LAT'({win_dly_q, vld_p2_q});

        // OUT: invert, blink gate, colour
        rom_bit_v   = rom_q ^ bus.invert_en;
        pix_on_d    = win_dly_q[ROM_LAT-1] & rom_bit_v & (~bus.blink_en | blink_phase_q);
        pix_color_d = pix_on_d ? bus.fg_color : '0;

        cur_sprite_d  = cur_sprite_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (bus.frame_start) begin
            if (32'(bus.sprite_sel) < 32'(NUM_SPRITES)) begin
                cur_sprite_d = bus.sprite_sel;
            end
            if (blink_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q      <= 1'b0;
            vld_p2_q      <= 1'b0;
            win_dly_q     <= '0;
            pix_on_q      <= 1'b0;
            pix_color_q   <= '0;
            cur_sprite_q  <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
        end else begin
            vld_p1_q      <= vld_p1_d;
            vld_p2_q      <= vld_p2_d;
            win_dly_q     <= win_dly_d;
            pix_on_q      <= pix_on_d;
            pix_color_q   <= pix_color_d;
            cur_sprite_q  <= cur_sprite_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    always_ff @(posedge clk) begin
        rc_p1_q   <= rc_p1_d;
        rr_p1_q   <= rr_p1_d;
        spr_p1_q  <= spr_p1_d;
        addr_p2_q <= addr_p2_d;
    end

    sprite_overlay_rom #(
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .ROM_LAT (ROM_LAT)
    ) u_rom (
        .clk  (clk),
        .addr (addr_p2_q),
        .q    (rom_q)
    );

    assign bus.pix_on     = pix_on_q;
    assign bus.pix_color  = pix_color_q;
    assign bus.cur_sprite = cur_sprite_q;
endmodule
